cmp_sort_ctrl: RTL and testbench

- Sequencing controller that sorts up to DEPTH unsigned WIDTH-bit values in ascending order by time-sharing one external combinational magnitude comparator.
- The comparator has agb/alb/aeb outputs and an active-high reset input.
- The controller owns the value buffer, drives the comparator operands, and performs an in-place bubble sort, one compare per cycle.
- It sits between a loader/reader and the shared comparator.

---
 rtl/cmp_sort_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl
//   Sorts up to DEPTH unsigned WIDTH-bit values into ascending order with an
//   in-place bubble sort.  A single external combinational magnitude
//   comparator is time-shared: one compare is issued per SORT cycle and its
//   result decides whether the two adjacent entries are swapped.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   wr_en, wr_data      append a value (IDLE only)
//   start               begin sorting (IDLE only)
//   clear               leave DONE, empty the buffer, drop err
//   rd_addr, rd_data    combinational read of the buffer
//   count, full         number of loaded entries, count==DEPTH
//   busy, done          state indicators (SORT / DONE)
//   err                 comparator returned a non-one-hot result (sticky)
//   cmp_count           compares issued by the last sort (saturating)
//   cmp_a, cmp_b        comparator operands, cmp_rst comparator reset
//   cmp_agb/alb/aeb     comparator results, same cycle
module cmp_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    cmp_count,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_rst,
  input  logic             cmp_agb,
  input  logic             cmp_alb,
  input  logic             cmp_aeb
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0]       state, state_nx;
  logic [AW:0]      cnt;
  logic [AW-1:0]    j, j1, pass;
  logic             swapped;
  logic [CW-1:0]    ccnt;
  logic             err_q;
  logic             cmp_rst_q;

  logic             wr_ok;
  logic [AW:0]      cnt_after;
  logic [WIDTH-1:0] op_a, op_b;
  logic             onehot;
  logic             do_swap;
  logic             swapped_now;
  logic [AW:0]      last_j;
  logic             pass_end;
  logic             final_pass;
  logic             sort_over;

  assign j1   = j + AW'(1);
  assign op_a = mem[j];
  assign op_b = mem[j1];

  assign rd_data   = mem[rd_addr];
  assign count     = cnt;
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign busy      = (state == SORT);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign cmp_count = ccnt;
  assign cmp_rst   = cmp_rst_q;
  // Operands are only meaningful while sorting; park them at zero otherwise.
  assign cmp_a     = (state == SORT) ? op_a : '0;
  assign cmp_b     = (state == SORT) ? op_b : '0;

  always_comb begin
    wr_ok       = wr_en && (cnt < (AW+1)'(DEPTH));
    cnt_after   = wr_ok ? cnt + (AW+1)'(1) : cnt;
    onehot      = (cmp_agb & ~cmp_alb & ~cmp_aeb) |
                  (~cmp_agb & cmp_alb & ~cmp_aeb) |
                  (~cmp_agb & ~cmp_alb & cmp_aeb);
    do_swap     = onehot & cmp_agb;
    // The swap decided this cycle must count toward the early-exit test.
    swapped_now = swapped | do_swap;
    // Each pass bubbles the largest remaining value to the end, so the
    // compare window shrinks by one entry per pass.
    last_j      = cnt - (AW+1)'(2) - {1'b0, pass};
    pass_end    = ({1'b0, j} == last_j);
    final_pass  = ({1'b0, pass} == cnt - (AW+1)'(2));
    sort_over   = pass_end && (!swapped_now || final_pass);

    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (cnt_after >= (AW+1)'(2)) ? SORT : DONE;
      SORT:    if (!onehot || sort_over) state_nx = DONE;
      DONE:    if (clear) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      j         <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      ccnt      <= '0;
      err_q     <= 1'b0;
      cmp_rst_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_nx;
      cmp_rst_q <= (state_nx != SORT);
      case (state)
        IDLE: begin
          // Write is taken first; start then sees the updated count.
          if (wr_ok) begin
            mem[cnt[AW-1:0]] <= wr_data;
            cnt              <= cnt_after;
          end
          if (start) begin
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            ccnt    <= '0;
          end
        end
        SORT: begin
          ccnt <= sat_inc(ccnt);
          if (!onehot) begin
            err_q <= 1'b1;
          end else begin
            if (do_swap) begin
              mem[j]  <= op_b;
              mem[j1] <= op_a;
            end
            if (pass_end) begin
              if (!sort_over) begin
                pass    <= pass + AW'(1);
                j       <= '0;
                swapped <= 1'b0;
              end
            end else begin
              j       <= j1;
              swapped <= swapped_now;
            end
          end
        end
        DONE: begin
          if (clear) begin
            cnt   <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
module tb_cmp_sort_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       start;
  logic       clear;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] count;
  logic       full, busy, done, err;
  logic [7:0] cmp_count;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_rst;
  logic       cmp_agb, cmp_alb, cmp_aeb;
  logic       bad;

  int n_tests = 0;
  int n_fail  = 0;

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .busy(busy), .done(done), .err(err),
    .cmp_count(cmp_count), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_rst(cmp_rst),
    .cmp_agb(cmp_agb), .cmp_alb(cmp_alb), .cmp_aeb(cmp_aeb)
  );

  // Behavioural stand-in for the shared comparator; 'bad' injects an
  // illegal two-hot result.
  always_comb begin
    if (bad)          {cmp_agb, cmp_alb, cmp_aeb} = 3'b110;
    else if (cmp_rst) {cmp_agb, cmp_alb, cmp_aeb} = 3'b000;
    else              {cmp_agb, cmp_alb, cmp_aeb} = {cmp_a > cmp_b, cmp_a < cmp_b, cmp_a == cmp_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    wr_en   = 1'b1;
    wr_data = 4'(v);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_done(output int ncyc, output int nrst);
    ncyc = 0;
    nrst = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      if (!cmp_rst) nrst++;
      step();
    end
  endtask

  task automatic rd(input int a, input int exp, input string tag);
    rd_addr = 3'(a);
    #1;
    check(tag, int'(rd_data), exp);
  endtask

  int ncyc, nrst;
  int basic_exp [4] = '{1, 1, 4, 10};

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    clear = 1'b0; rd_addr = '0; bad = 1'b0;
    step(); step();
    reset = 1'b0;

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_cmp_rst", cmp_rst, 1);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_err", err, 0);

    // basic sort: 4,1,10,1 -> 1,1,4,10 in 6 compares
    load(4); load(1); load(10); load(1);
    check("basic_count", count, 4);
    kick();
    check("basic_busy", busy, 1);
    check("basic_op_a", cmp_a, 4);
    check("basic_op_b", cmp_b, 1);
    wait_done(ncyc, nrst);
    check("basic_cycles", ncyc, 6);
    check("basic_rst_low", nrst, 6);
    check("basic_done", done, 1);
    check("basic_cmp_count", cmp_count, 6);
    check("basic_err", err, 0);
    check("basic_cmp_rst_done", cmp_rst, 1);
    for (int i = 0; i < 4; i++) rd(i, basic_exp[i], "basic_rd");
    do_clear();
    check("clr_done", done, 0);
    check("clr_count", count, 0);
    check("clr_cmp_count_kept", cmp_count, 6);
    rd(0, 0, "clr_mem0");

    // already ascending + full buffer: ninth write ignored, one pass
    for (int i = 0; i < 8; i++) load(i);
    check("full_flag", full, 1);
    load(15);
    check("full_count", count, 8);
    kick();
    wait_done(ncyc, nrst);
    check("asc_cycles", ncyc, 7);
    check("asc_cmp_count", cmp_count, 7);
    for (int i = 0; i < 8; i++) rd(i, i, "asc_rd");
    do_clear();

    // worst case reverse order
    for (int i = 7; i >= 0; i--) load(i);
    kick();
    wait_done(ncyc, nrst);
    check("rev_busy_cycles", ncyc, 28);
    check("rev_cmp_count", cmp_count, 28);
    for (int i = 0; i < 8; i++) rd(i, i, "rev_rd");
    do_clear();

    // single entry: straight to DONE with no compares
    load(5);
    kick();
    check("short_done", done, 1);
    check("short_busy", busy, 0);
    check("short_cmp_count", cmp_count, 0);
    rd(0, 5, "short_rd0");
    do_clear();

    // protocol error on first compare: no swap, DONE next cycle
    load(3); load(2);
    kick();
    check("perr_busy", busy, 1);
    bad = 1'b1;
    step();
    bad = 1'b0;
    check("perr_done", done, 1);
    check("perr_err", err, 1);
    check("perr_cmp_count", cmp_count, 1);
    rd(0, 3, "perr_rd0");
    rd(1, 2, "perr_rd1");
    do_clear();
    check("perr_clr_err", err, 0);
    check("perr_clr_count", count, 0);

    // reset on third SORT cycle discards everything
    for (int i = 7; i >= 0; i--) load(i);
    kick();
    step(); step();
    check("mrst_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_count", count, 0);
    check("mrst_cmp_rst", cmp_rst, 1);
    for (int i = 0; i < 8; i++) rd(i, 0, "mrst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
